// File: rtl/lv_abist_stim.sv
// lv_abist_stim: analog BIST stimulus sequencer. Forces each comparator in turn and checks its assert/clear windows.
// Registered outputs, force rises 1 cycle after start, no backpressure; define LV_ABIST_STIM_RETRY_EN for one retry per failed channel.
module lv_abist_stim #(
  parameter int CLK_M    = 48,
  parameter int CH_NUM   = 4,
  parameter int FORCE_US = 70,
  parameter int REL_US   = 20,
  parameter int GAP_US   = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bist_en,
  input  logic              i_bist_start,
  input  logic [CH_NUM-1:0] i_cmp_rsp,
  output logic [CH_NUM-1:0] o_bist_force,
  output logic              o_bist_busy,
  output logic              o_bist_done,
  output logic [CH_NUM-1:0] o_bist_pass,
  output logic              o_bist_abort
`ifdef LV_ABIST_STIM_RETRY_EN
  ,
  output logic [CH_NUM-1:0] o_bist_retry
`endif
);

  localparam int FORCE_CYC = FORCE_US * CLK_M;
  localparam int REL_CYC   = REL_US * CLK_M;
  localparam int GAP_CYC   = GAP_US * CLK_M;
  localparam int MAX_FR    = (FORCE_CYC > REL_CYC) ? FORCE_CYC : REL_CYC;
  localparam int MAX_CYC   = (MAX_FR > GAP_CYC) ? MAX_FR : GAP_CYC;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [CNT_W-1:0] FORCE_LAST = CNT_W'(FORCE_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(REL_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(CH_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FORCE   = 3'd1,
    S_RELEASE = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic [CH_NUM-1:0] force_q, force_d;
  logic [CH_NUM-1:0] pass_q, pass_d;
  logic              abort_q, abort_d;
  logic [CH_NUM-1:0] rsp_m_q, rsp_m_d;
  logic [CH_NUM-1:0] rsp_s_q, rsp_s_d;
`ifdef LV_ABIST_STIM_RETRY_EN
  logic [CH_NUM-1:0] retry_q, retry_d;
  logic              again_q, again_d;
`endif

  logic             busy;
  logic             rsp_ch;
  logic             released;
  logic             ch_ok;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    rsp_m_d  = i_cmp_rsp;
    rsp_s_d  = rsp_m_q;
    state_d  = state_q;
    ch_d     = ch_q;
    hit_d    = hit_q;
    pass_d   = pass_q;
    abort_d  = 1'b0;
    released = 1'b0;
    ch_ok    = 1'b0;
    rsp_ch   = rsp_s_q[ch_q];
    busy     = (state_q == S_FORCE) || (state_q == S_RELEASE) || (state_q == S_GAP);
    // Terminal value holds rather than wrapping.
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    cnt_d    = cnt_inc;
`ifdef LV_ABIST_STIM_RETRY_EN
    retry_d  = retry_q;
    again_d  = again_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_bist_en && i_bist_start) begin
          pass_d  = '0;
          ch_d    = '0;
          state_d = S_FORCE;
`ifdef LV_ABIST_STIM_RETRY_EN
          retry_d = '0;
          again_d = 1'b0;
`endif
        end
      end
      S_FORCE: begin
        // Response already high on the first force cycle means a stuck comparator.
        if (rsp_ch) begin
          hit_d   = (cnt_q != '0);
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (cnt_q == FORCE_LAST) begin
          hit_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!rsp_ch || (cnt_q == REL_LAST)) begin
          released     = !rsp_ch;
          ch_ok        = hit_q & released;
          pass_d[ch_q] = ch_ok;
          cnt_d        = '0;
          state_d      = S_GAP;
`ifdef LV_ABIST_STIM_RETRY_EN
          if (!ch_ok && !retry_q[ch_q]) begin
            retry_d[ch_q] = 1'b1;
            again_d       = 1'b1;
          end
`endif
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
`ifdef LV_ABIST_STIM_RETRY_EN
          if (again_q) begin
            again_d = 1'b0;
            state_d = S_FORCE;
          end else
`endif
          if (ch_q == CH_LAST) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_FORCE;
          end
        end
      end
      S_DONE: begin
        cnt_d = '0;
        if (!i_bist_en) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Enable loss mid-sequence overrides every transition above.
    if (busy && !i_bist_en) begin
      state_d = S_IDLE;
      pass_d  = '0;
      abort_d = 1'b1;
      cnt_d   = '0;
      ch_d    = '0;
      hit_d   = 1'b0;
`ifdef LV_ABIST_STIM_RETRY_EN
      again_d = 1'b0;
`endif
    end

    force_d = (state_d == S_FORCE) ? (CH_NUM'(1) << ch_d) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      force_q <= '0;
      pass_q  <= '0;
      abort_q <= 1'b0;
      rsp_m_q <= '0;
      rsp_s_q <= '0;
`ifdef LV_ABIST_STIM_RETRY_EN
      retry_q <= '0;
      again_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      force_q <= force_d;
      pass_q  <= pass_d;
      abort_q <= abort_d;
      rsp_m_q <= rsp_m_d;
      rsp_s_q <= rsp_s_d;
`ifdef LV_ABIST_STIM_RETRY_EN
      retry_q <= retry_d;
      again_q <= again_d;
`endif
    end
  end

  assign o_bist_force = force_q;
  assign o_bist_busy  = busy;
  assign o_bist_done  = (state_q == S_DONE);
  assign o_bist_pass  = pass_q;
  assign o_bist_abort = abort_q;
`ifdef LV_ABIST_STIM_RETRY_EN
  assign o_bist_retry = retry_q;
`endif

endmodule

// File: doc/lv_abist_stim.md
Name: lv_abist_stim

Overview:
- Stimulus sequencer for the lv analog BIST; it is the initiator side of the comparator-forcing handshake.
- On start, walks CH_NUM analog comparators (vsup ov/uv, ot, ...) one at a time.
- For each channel: drives a force line, checks that the comparator response asserts within a window, releases the force, and checks that the response clears.
- Produces a per-channel pass vector, a done flag and an abort pulse for the lv top-level fault logic.

Parameters:
- CLK_M, 48, clock cycles per us (common parameter set)
- CH_NUM, 4, number of comparator channels tested, 1..8
- FORCE_US, 70, max response window after force assert, us
- REL_US, 20, max release window after force deassert, us
- GAP_US, 5, quiet time between channels, us
- Derived: FORCE_CYC=FORCE_US*CLK_M; REL_CYC=REL_US*CLK_M; GAP_CYC=GAP_US*CLK_M
- Derived: CNT_W=$clog2(max(FORCE_CYC,REL_CYC,GAP_CYC)+1)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  async active-low reset
- i_bist_en  in  1  bist mode enable; low aborts or clears
- i_bist_start  in  1  1-cycle start pulse, honoured only in IDLE with i_bist_en=1
- i_cmp_rsp  in  CH_NUM  raw analog comparator outputs, asynchronous
- o_bist_force  out  CH_NUM  one-hot force to analog, registered
- o_bist_busy  out  1  high in any state other than IDLE/DONE
- o_bist_done  out  1  sequence complete, held until i_bist_en=0
- o_bist_pass  out  CH_NUM  per-channel result, valid when o_bist_done=1
- o_bist_abort  out  1  1-cycle pulse when i_bist_en drops while busy

Behaviour:
- Clock/reset: one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
- Reset values: all outputs 0, state IDLE, ch=0, cnt=0, sync flops 0.
- Response sync: i_cmp_rsp goes through a 2-flop synchroniser per bit to give rsp_s. All checks use rsp_s[ch]. Sync latency of 2 cycles is counted inside the windows.
- State IDLE:
  - On i_bist_en & i_bist_start: clear o_bist_pass, set ch=0, cnt=0, go to FORCE.
  - o_bist_force[0] rises on the cycle after the start pulse.
- State FORCE:
  - o_bist_force = one-hot(ch); cnt increments each cycle.
  - cnt==0 and rsp_s[ch]==1: stuck-high. Mark ch failed, go to RELEASE.
  - cnt>=1 and rsp_s[ch]==1: hit=1, cnt=0, go to RELEASE.
  - cnt==FORCE_CYC-1 with no hit: fail, go to RELEASE.
  - A hit on the same cycle as the timeout counts as a hit.
- State RELEASE:
  - o_bist_force=0; cnt counts.
  - rsp_s[ch]==0: released=1, go to GAP.
  - cnt==REL_CYC-1: timeout, released=0, go to GAP.
  - On GAP entry: o_bist_pass[ch] <= hit & released.
- State GAP:
  - Force stays 0; wait GAP_CYC cycles.
  - Then if ch==CH_NUM-1, go to DONE; else ch++, cnt=0, go to FORCE.
- State DONE:
  - o_bist_done=1, o_bist_busy=0, pass vector held.
  - i_bist_en=0: go to IDLE, done=0; pass is kept until the next start.
  - i_bist_start in DONE is ignored.
- Abort: i_bist_en=0 in FORCE/RELEASE/GAP
  - next cycle: o_bist_force=0, state IDLE, o_bist_pass=0, o_bist_abort=1 for one cycle.
  - Takes priority over every other transition on the same cycle.
- Other invariants:
  - Only one force bit is ever high.
  - Force is never high in IDLE/GAP/DONE.
  - Reset mid-sequence drops force asynchronously.
  - Counters saturate at their terminal value and never wrap.

Optional Feature:
- Macro: LV_ABIST_STIM_RETRY_EN.
- Defined:
  - A channel that fails FORCE or RELEASE is retried once: GAP, then FORCE on the same ch.
  - The pass bit reflects the second attempt only.
  - A per-channel retried flag is kept internally and exported on extra port o_bist_retry [CH_NUM], cleared on start.
- Undefined: no retry, no o_bist_retry port; the first result is final.

Test Plan:
- Default params, all comparators respond 10us after force and clear 2us after release -> sequence finishes; o_bist_pass=4'b1111; o_bist_done=1; total busy time about 4*(10+2+5)us plus sync cycles.
- ch2 never responds -> force[2] high exactly FORCE_CYC=3360 cycles; o_bist_pass=4'b1011; done asserted.
- ch1 response held high before its force -> stuck-high detected at cnt==0; pass[1]=0; release timeout of 960 cycles observed.
- i_bist_en dropped during FORCE of ch1 -> next cycle o_bist_force=0, o_bist_abort pulses once, o_bist_pass=0, busy=0; a new start runs from ch0.
- Start pulse in DONE, then i_bist_en low -> start ignored, done clears, pass retained; async reset mid-RELEASE -> all outputs 0 immediately.
- With LV_ABIST_STIM_RETRY_EN, ch3 fails the first attempt and passes the second -> pass[3]=1, o_bist_retry=4'b1000.
